mul_seq_unit: RTL
=================

Name: mul_seq_unit

Overview:
- Multi-cycle shift-add unsigned multiplier directly upstream of the dual-read-port data RAM.
- Takes two operands (normally the RAM's two read-port outputs) and produces a DATA_WIDTH-bit result plus a one-cycle write strobe.
- The strobe and low result connect to the RAM's multiply-write inputs (iMulEnable, iDataInMul); the RAM stores the result at its fixed multiply slot, address 8.
- Replaces a combinational multiplier on the datapath critical path.

Parameters:
- DATA_WIDTH, 16, operand width and RAM data width.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- Clock  input  1  single design clock, rising-edge.
- Reset  input  1  synchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE.
- iOperandA  input  DATA_WIDTH  multiplicand, latched on accepted start.
- iOperandB  input  DATA_WIDTH  multiplier, latched on accepted start.
- oBusy  output  1  high in RUN and DONE.
- oDone  output  1  one-cycle completion pulse.
- oMulEnable  output  1  RAM write strobe; identical to oDone.
- oProductLow  output  DATA_WIDTH  product bits [DATA_WIDTH-1:0]; drives RAM iDataInMul.
- oProductHigh  output  DATA_WIDTH  product bits [2*DATA_WIDTH-1:DATA_WIDTH].
- oOverflow  output  1  high when oProductHigh != 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named Clock and Reset.
- Reset (at any edge, including mid-operation):
  - state=IDLE.
  - oBusy, oDone, oMulEnable, oOverflow = 0.
  - Accumulator, multiplicand and multiplier registers cleared; oProductLow and oProductHigh = 0.
  - Counter = 0.
  - An operation in progress is aborted with no strobe.
- States:
  - IDLE: when iStart=1 at an edge, latch A into a 2*DATA_WIDTH multiplicand register (zero-extended), latch B into the multiplier register, clear the accumulator, set counter=DATA_WIDTH, and go to RUN. Otherwise stay in IDLE.
  - RUN: one iteration per edge:
    - if B[0]=1, acc <= acc + Ashift; the sum is 2*DATA_WIDTH wide and cannot overflow.
    - Ashift <= Ashift<<1; B <= B>>1; counter--.
    - When the counter reaches 0 on that edge, go to DONE.
  - DONE: lasts one cycle. oDone=oMulEnable=1; returns to IDLE at the next edge.
- oProductLow, oProductHigh and oOverflow are driven from the accumulator.
  - They are valid and stable during the DONE cycle.
  - They are held until the next accepted start clears the accumulator.
- Latency: with start accepted at edge N, the DONE cycle follows edge N+DATA_WIDTH (default: 16 iterations), and the unit is back in IDLE after edge N+DATA_WIDTH+1.
- iStart in RUN or DONE is ignored, not queued.
- Back-to-back operation: a start in the first IDLE cycle after DONE is accepted. Minimum start-to-start spacing is DATA_WIDTH+2 cycles.
- Operands may change after the start edge without affecting the result.
- The unit is purely unsigned; the product is exact in 2*DATA_WIDTH bits.

Optional Feature:
- MUL_EARLY_EXIT_EN defined:
  - In RUN, also go to DONE on any edge where the next value of B (B>>1) is zero.
  - B=0 or B=1: DONE follows edge N+1. In general DONE follows edge N+k+1, where k = index of the highest set bit of B.
  - Latency is never worse than the fixed case; results are identical.
- Not defined: fixed DATA_WIDTH iterations; deterministic latency.

Decomposition:
- Shared package mul_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default DATA_WIDTH constant (16).
  - RAM multiply-slot address constant (8'd8), shared with the RAM integration.
- One natural sub-module, mul_shift_add_datapath:
  - Contains the accumulator, shifted multiplicand, multiplier shift register, and zero-detect of the next B.
  - Control inputs: load and step.
- FSM and counter stay in mul_seq_unit.

Test Plan:
- Reset 2 cycles, then A=3, B=5, start at edge N -> single oDone/oMulEnable pulse in the cycle after edge N+16; oProductLow=0x000F, oProductHigh=0, oOverflow=0; oBusy high for cycles N+1..N+16.
- A=0xFFFF, B=0xFFFF -> oProductLow=0x0001, oProductHigh=0xFFFE, oOverflow=1; outputs held constant for 10 idle cycles afterwards.
- A=7, B=9 started; iStart pulsed with A=2, B=2 at edge N+4 and during the DONE cycle -> result 0x003F; exactly one strobe; next result unaffected.
- Start A=0x1234, B=0x0010; assert Reset at edge N+6 -> no strobe ever; all outputs 0 after the reset edge; new start (A=2, B=3) -> 0x0006.
- Start in the first IDLE cycle after DONE, A=0x0100, B=0x0100 -> accepted; oProductHigh=0x0001, oProductLow=0x0000, oOverflow=1.
- With MUL_EARLY_EXIT_EN: B=0x0004, A=0x0011 -> DONE after edge N+3, result 0x0044; B=0 -> DONE after edge N+1, result 0. Without the macro, both cases finish after edge N+16.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared state encoding and constants for the sequential multiplier and its
// hookup to the data RAM multiply slot.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_DATA_WIDTH = 16;

  // Fixed RAM address where the low product word is written.
  localparam logic [7:0] MUL_RAM_SLOT_ADDR = 8'd8;

endpackage

// File: rtl/mul_shift_add_datapath.sv
// Shift-add datapath: accumulator, shifted multiplicand and multiplier shift
// register; load latches fresh operands, step performs one iteration.
module mul_shift_add_datapath
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      load,
  input  logic                      step,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  output logic [2*DATA_WIDTH-1:0]   acc,
  output logic                      next_b_zero
);

  logic [2*DATA_WIDTH-1:0] acc_r;
  logic [2*DATA_WIDTH-1:0] ashift_r;
  logic [DATA_WIDTH-1:0]   b_r;

  // Operand load on start, then one conditional add and shift per step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_r    <= {(2*DATA_WIDTH){1'b0}};
      ashift_r <= {(2*DATA_WIDTH){1'b0}};
      b_r      <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      acc_r    <= {(2*DATA_WIDTH){1'b0}};
      ashift_r <= {{DATA_WIDTH{1'b0}}, operand_a};
      b_r      <= operand_b;
    end else if (step) begin
      if (b_r[0]) begin
        acc_r <= acc_r + ashift_r;
      end else begin
        acc_r <= acc_r;
      end
      ashift_r <= {ashift_r[2*DATA_WIDTH-2:0], 1'b0};
      b_r      <= {1'b0, b_r[DATA_WIDTH-1:1]};
    end else begin
      acc_r    <= acc_r;
      ashift_r <= ashift_r;
      b_r      <= b_r;
    end
  end

  assign acc         = acc_r;
  // True when the multiplier will be exhausted after the current step.
  assign next_b_zero = (b_r[DATA_WIDTH-1:1] == {(DATA_WIDTH-1){1'b0}});

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential unsigned shift-add multiplier feeding the RAM multiply slot.
// Define MUL_EARLY_EXIT_EN to finish as soon as the multiplier runs out of set bits.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iOperandA,
  input  logic [DATA_WIDTH-1:0] iOperandB,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oMulEnable,
  output logic [DATA_WIDTH-1:0] oProductLow,
  output logic [DATA_WIDTH-1:0] oProductHigh,
  output logic                  oOverflow
);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  mul_state_e              state_r;
  mul_state_e              state_next_s;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic                    load_s;
  logic                    step_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    last_iter_s;
  logic                    next_b_zero_s;
  logic [2*DATA_WIDTH-1:0] acc_s;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; starts outside IDLE are dropped.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (iStart) state_next_s = RUN;
        else        state_next_s = IDLE;
      end
      RUN: begin
        if (last_iter_s) state_next_s = DONE;
        else             state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output and datapath control decode.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: load_s = iStart;
      RUN: begin
        step_s = 1'b1;
        busy_s = 1'b1;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
  end

  // Iteration counter; loaded on start, counts down once per step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_r <= CNT_ZERO;
    end else if (load_s) begin
      cnt_r <= CNT_LOAD;
    end else if (step_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last_iter_s = (cnt_r == CNT_ONE) || (EARLY_EXIT && next_b_zero_s);

  mul_shift_add_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .Clock       (Clock),
    .Reset       (Reset),
    .load        (load_s),
    .step        (step_s),
    .operand_a   (iOperandA),
    .operand_b   (iOperandB),
    .acc         (acc_s),
    .next_b_zero (next_b_zero_s)
  );

  assign oBusy        = busy_s;
  assign oDone        = done_s;
  assign oMulEnable   = done_s;
  assign oProductLow  = acc_s[DATA_WIDTH-1:0];
  assign oProductHigh = acc_s[2*DATA_WIDTH-1:DATA_WIDTH];
  assign oOverflow    = |acc_s[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule
